tff1: RTL and testbench
=======================

Name: tff1

Overview:
- Bank of toggle (T) flip-flops; each output bit inverts on a rising clock edge when its T input is high, and holds otherwise.
- Default configuration is a single T flip-flop (T -> A0).
- Also provides a synchronous clear, a parallel load, a per-cycle "changed" pulse and a saturating toggle-event counter for status/debug.
- Used as a building block for dividers, ripple/synchronous counters and parity trackers.

Parameters:
- WIDTH, 1, number of independent T flip-flops (bits of T and A0).
- CNT_W, 8, width of the toggle-event counter.
- RST_VAL, 0, WIDTH-bit value A0 takes on reset and on clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- T  in  WIDTH  per-bit toggle enable, sampled at rising clk.
- clr  in  1  synchronous clear of A0 to RST_VAL; tie 0 if unused.
- load  in  1  synchronous parallel load of A0 from din; tie 0 if unused.
- din  in  WIDTH  load data.
- A0  out  WIDTH  flip-flop state (registered).
- changed  out  1  registered pulse, high for the cycle after any A0 bit changed.
- tcount  out  CNT_W  number of clock edges on which at least one bit toggled; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, independent of clk):
  - A0 = RST_VAL, changed = 0, tcount = 0.
  - Deassertion takes effect at the next rising edge; no edge-sensitive action occurs on deassertion itself.
- Per rising edge, priority order:
  1. clr=1: A0 <= RST_VAL.
  2. else load=1: A0 <= din.
  3. else: A0 <= A0 ^ T (bit i inverts iff T[i]=1).
- Latency:
  - A0 reflects T sampled at edge n immediately after edge n, i.e. one-register latency.
  - No combinational path from T to A0.
- changed:
  - changed <= (next A0 != current A0), evaluated at the same edge.
  - Clear or load to an identical value gives changed=0.
- tcount:
  - Increments by 1 at an edge where state 3 applies and T != 0.
  - clr and load edges do not count, and they do not reset tcount; only rst_n resets it.
  - Saturates at 2^CNT_W-1; no wrap.
- T=0 on all bits: A0 holds indefinitely and tcount is unchanged.
- T held at 1 continuously: the bit toggles every edge, giving a clk/2 square wave.
- Simultaneous clr and load: clr wins.
- Simultaneous load and nonzero T: load wins, T is ignored, and the edge is not counted.
- Reset asserted mid-operation overrides everything asynchronously.
- Inputs are assumed synchronous to clk and meeting setup/hold; no internal synchronizers.

Decomposition:
- Shared package: CNT_W default constant and the RST_VAL default.
- One natural sub-module, tff_bit: single T flip-flop with async active-low reset, clr, load and T.
  - Generate WIDTH instances of tff_bit.
  - Keep the changed/tcount logic in tff1.

Test Plan:
- Reset: assert rst_n=0 with clk stopped -> A0=0, changed=0, tcount=0 immediately; release -> all hold until the first edge.
- Alternating toggle (WIDTH=1): after reset, drive T=1,0,1,0,... (10 edges, T changed between edges) -> A0 after each edge = 1,1,0,0,1,1,0,0,1,1; tcount=5.
- Continuous T=1 for 6 edges -> A0 = 1,0,1,0,1,0; changed high every cycle; tcount=6.
- Priority: A0=1, clr=1, load=1, din=1, T=1 at the same edge -> A0=0, tcount unchanged; next edge with load=1, din=1, T=1 -> A0=1, not counted.
- Saturation: CNT_W=2, T=1 for 5 edges -> tcount = 1,2,3,3,3.
- Async reset mid-run: assert rst_n=0 between edges while A0=1 -> A0 goes to 0 without a clock edge; tcount goes to 0.

Source files
------------

// File: rtl/tff1_pkg.sv
// Shared defaults and helpers for the tff1 toggle flip-flop bank.
package tff1_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_RST_VAL = 0;

    // An edge counts only when the plain toggle path is active and some bit toggles.
    function automatic logic counts_edge(input logic clr, input logic load, input logic t_any);
        return !clr && !load && t_any;
    endfunction

endpackage

// File: rtl/tff1_bit.sv
// Single T flip-flop: clear beats load, load beats toggle.
module tff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic clr,
    input  logic load,
    input  logic din,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= din;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff1.sv
// Bank of WIDTH toggle flip-flops with clear, load, change pulse and saturating toggle counter.
module tff1
    import tff1_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] T,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] A0,
    output logic             changed,
    output logic [CNT_W-1:0] tcount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] next_a;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            tff_bit #(
                .RST_VAL(RST_VAL[i])
            ) u_bit (
                .clk  (clk),
                .rst_n(rst_n),
                .t    (T[i]),
                .clr  (clr),
                .load (load),
                .din  (din[i]),
                .q    (A0[i])
            );
        end
    endgenerate

    // Mirror of the per-bit update, used only to detect whether this edge changes A0.
    always_comb begin
        next_a = A0 ^ T;
        if (clr) begin
            next_a = RST_VAL;
        end else if (load) begin
            next_a = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
            tcount  <= '0;
        end else begin
            changed <= (next_a != A0);
            if (counts_edge(clr, load, |T) && (tcount != CNT_MAX)) begin
                tcount <= tcount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tff1.sv
// Scoreboard bench for tff1: driver pushes model predictions, monitor pops and compares after each edge.
module tb_tff1;

    localparam int         WIDTH   = 4;
    localparam int         CNT_W   = 3;
    localparam logic [3:0] RST_VAL = 4'b0110;
    localparam int         CNT_SAT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic             ch;
        logic [CNT_W-1:0] cnt;
    } expect_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] T;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] A0;
    logic             changed;
    logic [CNT_W-1:0] tcount;

    logic clk_run;
    int   tests_run;
    int   tests_failed;

    expect_t          sb_q[$];
    logic [WIDTH-1:0] m_a;
    int               m_cnt;

    tff1 #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .T      (T),
        .clr    (clr),
        .load   (load),
        .din    (din),
        .A0     (A0),
        .changed(changed),
        .tcount (tcount)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one edge, written straight from the update rules.
    task automatic applyStimulus(input logic [WIDTH-1:0] t_in, input logic clr_in,
                                 input logic load_in, input logic [WIDTH-1:0] din_in);
        expect_t          e;
        logic [WIDTH-1:0] nxt;
        @(negedge clk);
        T    = t_in;
        clr  = clr_in;
        load = load_in;
        din  = din_in;
        if (clr_in)       nxt = RST_VAL;
        else if (load_in) nxt = din_in;
        else begin
            nxt = m_a ^ t_in;
            if (t_in != 0 && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
        end
        e.ch  = (nxt != m_a);
        m_a   = nxt;
        e.a   = m_a;
        e.cnt = CNT_W'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " A0"}, int'(A0), int'(RST_VAL));
        checkOutput({tag, " changed"}, int'(changed), 0);
        checkOutput({tag, " tcount"}, int'(tcount), 0);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("A0", int'(A0), int'(e.a));
                checkOutput("changed", int'(changed), int'(e.ch));
                checkOutput("tcount", int'(tcount), int'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int wait_cycles;
        tests_run    = 0;
        tests_failed = 0;
        clk_run      = 1'b0;
        rst_n        = 1'b1;
        T            = '0;
        clr          = 1'b0;
        load         = 1'b0;
        din          = '0;
        m_a          = RST_VAL;
        m_cnt        = 0;

        // Reset with the clock stopped, then release and confirm nothing moves.
        #2 rst_n = 1'b0;
        #1 checkReset("reset async");
        #5 rst_n = 1'b1;
        #3 checkReset("reset released hold");
        clk_run = 1'b1;

        // Alternating toggle on bit 0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 4'b0000);
        end

        // Asynchronous reset between edges while bit 0 is high.
        @(posedge clk);
        #2;
        checkOutput("pre-reset A0 bit0", int'(A0[0]), 1);
        T     = '0;
        clr   = 1'b0;
        load  = 1'b0;
        rst_n = 1'b0;
        #1 checkReset("reset mid-run");
        m_a   = RST_VAL;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous toggle on bit 0: clk/2 wave, counter runs into saturation.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000);
        end

        // Priority: clr over load over T, neither counted; then load identical value.
        applyStimulus(4'b1111, 1'b1, 1'b1, 4'b1111);
        applyStimulus(4'b1111, 1'b0, 1'b1, 4'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0001);
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);

        // Restart the counter so random traffic exercises it from zero again.
        @(posedge clk);
        #2;
        T     = '0;
        clr   = 1'b0;
        load  = 1'b0;
        rst_n = 1'b0;
        m_a   = RST_VAL;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            applyStimulus(4'($urandom_range(0, 15)) & ((i % 3 == 0) ? 4'b0000 : 4'b1111),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)));
        end
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);

        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checkOutput("scoreboard drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
